// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit words and writes
//   them to the instruction memory at byte addresses 0, 4, 8, ...
// Latency: word k is written the cycle after its 4th byte is accepted; done the
//   cycle after the last write. Throughput is at most 4 bytes per 5 cycles.
// Backpressure: byte_ready is high only in RECV; it drops for the WRITE cycle.
// Ports:
//   clk, reset (async, active-low)
//   start, num_words    : load request and length in words
//   byte_in, byte_valid, byte_ready : byte stream handshake
//   wr_en, wr_addr, wr_data         : instruction memory write port
//   cpu_hold, busy, done, error, checksum : status to the pipeline / host
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W:0]     r_num_words;
  logic [ADDR_W-1:0]   r_word_idx;
  logic [1:0]          r_byte_idx;
  // Only the first three bytes of a word are stored; the fourth goes straight
  // into the write data register.
  logic [23:0]         r_shift;
  logic [7:0]          r_checksum;
  logic                r_error;
  logic [31:0]         r_wr_addr;
  logic [31:0]         r_wr_data;

  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_accept;
  logic                w_last_byte;
  logic                w_last_word;

  assign w_len_ok    = (num_words != '0) &&
                       (num_words <= (ADDR_W+1)'(MAX_WORDS));
  assign w_start_ok  = (r_state == S_IDLE) && start && w_len_ok;
  assign w_start_bad = (r_state == S_IDLE) && start && !w_len_ok;
  assign w_accept    = byte_valid && byte_ready;
  assign w_last_byte = w_accept && (r_byte_idx == 2'd3);
  assign w_last_word = ({1'b0, r_word_idx} == (r_num_words - (ADDR_W+1)'(1)));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)  w_next = S_RECV;
      S_RECV:  if (w_last_byte) w_next = S_WRITE;
      S_WRITE: w_next = w_last_word ? S_DONE : S_RECV;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic; the pipeline is held in every non-idle state, so cpu_hold
  // drops exactly on the DONE -> IDLE transition.
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    cpu_hold   = 1'b0;
    case (r_state)
      S_RECV: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        cpu_hold   = 1'b1;
      end
      S_WRITE: begin
        wr_en    = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      S_DONE: begin
        done     = 1'b1;
        busy     = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: counters, byte assembly, checksum and error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_num_words <= '0;
      r_word_idx  <= '0;
      r_byte_idx  <= '0;
      r_shift     <= '0;
      r_checksum  <= '0;
      r_error     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      if (w_start_ok) begin
        r_num_words <= num_words;
        r_word_idx  <= '0;
        r_byte_idx  <= '0;
        r_checksum  <= '0;
        r_error     <= 1'b0;
      end else if (w_start_bad) begin
        r_error <= 1'b1;
      end

      if (w_accept) begin
        r_shift    <= {r_shift[15:0], byte_in};
        r_checksum <= r_checksum + byte_in;
        r_byte_idx <= r_byte_idx + 2'd1;   // wraps to 0 after the 4th byte
      end

      // Capture the write port one cycle early so it is valid during WRITE
      // and holds its value afterwards.
      if (w_last_byte) begin
        r_wr_data <= {r_shift, byte_in};
        r_wr_addr <= {{(30-ADDR_W){1'b0}}, r_word_idx, 2'b00};
      end

      if ((r_state == S_WRITE) && !w_last_word) begin
        r_word_idx <= r_word_idx + 1'b1;
        r_byte_idx <= '0;
      end
    end
  end

  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign error    = r_error;
  assign checksum = r_checksum;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that writes the instruction memory, which the fetch stage only ever reads.
- Accepts a byte stream over a valid/ready handshake and assembles bytes big-endian into 32-bit instruction words.
- Issues one write per word to the instruction memory write port at word-aligned byte addresses starting at 0.
- Holds the pipeline (cpu_hold) while a load is in progress and reports completion, errors and a byte checksum.

Parameters:
ADDR_W, 8, word-address width; capacity is 2^ADDR_W words.
MAX_WORDS, 256, largest legal load length in words; must be <= 2^ADDR_W.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  single-cycle request to begin a load; honoured only in IDLE.
num_words  input  ADDR_W+1  load length in words; sampled on an accepted start.
byte_in  input  8  stream data byte.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader can accept a byte this cycle.
wr_en  output  1  instruction memory write strobe, one cycle per word.
wr_addr  output  32  byte address of the word being written; bits [1:0] always 0.
wr_data  output  32  instruction word being written.
cpu_hold  output  1  high while a load is in progress; the pipeline stalls or holds its PC while high.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse when the last word has been written.
error  output  1  sticky flag for an illegal length; cleared by the next accepted start.
checksum  output  8  mod-256 sum of all bytes accepted in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE.
  - Outputs: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0, error=0, checksum=0.
  - Internal counters are cleared.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE:
  - byte_ready=0; bytes presented are ignored.
  - start=1 with 1 <= num_words <= MAX_WORDS: latch num_words, clear checksum, word_idx and byte_idx, clear error, and set cpu_hold=1. Go to RECV.
  - start=1 with num_words=0 or num_words>MAX_WORDS: set error=1 and stay in IDLE. No writes occur and cpu_hold stays 0.
- RECV:
  - byte_ready=1.
  - A byte is accepted when byte_valid & byte_ready; no other condition accepts a byte.
  - Each accepted byte: shift_reg <= {shift_reg[23:0], byte_in}, checksum <= checksum + byte_in (mod 256), byte_idx++.
  - The first byte of a word lands in bits [31:24].
  - On the 4th accepted byte (byte_idx=3), go to WRITE.
  - byte_valid low: hold state with no change; there is no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0, wr_en=1, wr_data=assembled word.
  - wr_addr = word_idx*4, zero-extended to 32 bits.
  - Next state: if word_idx == latched num_words-1, go to DONE; otherwise word_idx++, byte_idx=0, and go to RECV.
- DONE (one cycle):
  - done=1, byte_ready=0, wr_en=0.
  - cpu_hold falls to 0 on the transition to IDLE, so the pipeline resumes on the cycle after the done pulse.
- wr_addr and wr_data hold their last values when wr_en=0.
- Latency:
  - A start accepted at edge N puts the FSM in RECV after edge N.
  - Word k is written in the cycle after its 4th byte is accepted.
  - Maximum throughput is 4 bytes per 5 cycles.
- start while busy is ignored, with no effect on state, counters or error.
- Reset asserted mid-load aborts immediately: all outputs return to reset values and partial words are discarded. Words already written remain in memory.
- The checksum holds its final value in IDLE until the next accepted start.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, drive byte_valid=1 with no start -> all outputs 0, no wr_en, byte_ready=0.
- Single word: start with num_words=1, then bytes 0x20,0x08,0x00,0x05 back-to-back.
  - -> one wr_en pulse with wr_addr=0x00000000 and wr_data=0x20080005.
  - -> done pulses on the next cycle, checksum=0x2D, and cpu_hold is high from the cycle after start until after done.
- Three words with gaps: num_words=3 and random byte_valid gaps, words 0x11111111, 0x22222222, 0x33333333.
  - -> writes at addresses 0x0, 0x4 and 0x8 with matching data, exactly 3 wr_en pulses.
  - -> checksum=0x98 (12 bytes summed mod 256).
- Illegal length: start with num_words=0, then start with num_words=MAX_WORDS+1 -> error=1, busy=0, no wr_en.
  - A following start with num_words=1 -> error=0.
- Start while busy: during RECV of word 0 with num_words=2, pulse start with num_words=5 -> ignored; exactly 2 words written and done pulses once.
- Reset mid-load: num_words=2, assert reset after 6 bytes accepted -> outputs return to 0 immediately and only the word at address 0x0 was written.
  - A new load afterwards completes normally.
